fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the 16-bit processor.
- Drives the program counter and a single-outstanding req/ack read to instruction memory.
- Supplies the fetched word and a one-cycle load strobe to the instruction register, then presents the instruction to decode with a valid/ready handshake.
- Handles control-flow redirects, a HALT opcode, resume, and a fetch-timeout error.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 4'hF, value of instr[15:12] that halts fetch.
- TIMEOUT_CYCLES, 64, number of FETCH cycles without mem_ack before error (range 1..255).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_req  output  1  instruction memory read request.
- mem_addr  output  16  read address, equals pc.
- mem_ack  input  1  read complete, mem_rdata valid this cycle; sampled only while mem_req=1.
- mem_rdata  input  16  read data.
- ir_load  output  1  one-cycle strobe: instruction register captures ir_data on the next edge.
- ir_data  output  16  fetched instruction word (registered).
- instr_valid  output  1  instruction offered to decode.
- instr_ready  input  1  decode accepts the instruction.
- redirect  input  1  load redirect_pc as the next fetch address.
- redirect_pc  input  16  target address.
- resume  input  1  leave HALTED.
- pc  output  16  current fetch address.
- halted  output  1  high in HALTED.
- fetch_err  output  1  high in ERROR (sticky).

Behaviour:
- States: IDLE, FETCH, ISSUE, HALTED, ERROR. Outputs decode from state, except ir_load and ir_data, which are registered.
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir_data=16'h0000, timeout counter=0. All 1-bit outputs are 0.
- IDLE: all strobes low. Next cycle goes to FETCH unconditionally.
- FETCH: mem_req=1, mem_addr=pc. mem_addr is stable while mem_req=1.
  - mem_ack=1: ir_data<=mem_rdata, ir_load<=1 for exactly one cycle, pc<=pc+1 (16-bit wrap, 16'hFFFF->16'h0000), counter<=0, next state ISSUE.
  - No ack: counter increments. When counter==TIMEOUT_CYCLES-1 with no ack, next state is ERROR.
- Ack latency: minimum 1 cycle from mem_req rising to state ISSUE. ir_load and instr_valid both become 1 in the first ISSUE cycle.
- ISSUE: instr_valid=1, and it holds until instr_ready=1 (valid is never withdrawn without redirect).
  - On the accept cycle, if ir_data[15:12]==HALT_OPCODE, next state is HALTED; otherwise FETCH.
- HALTED: halted=1, mem_req=0. resume=1 moves to FETCH with pc unchanged (already past the HALT word).
- ERROR: fetch_err=1, all other strobes 0. Only rst_n exits. redirect and resume are ignored.
- Redirect (FETCH, ISSUE or HALTED) has priority over mem_ack, instr_ready and resume:
  - pc<=redirect_pc, counter<=0, next state IDLE.
  - mem_req drops for one cycle, which cancels any outstanding read; a simultaneous mem_ack is discarded and ir_load does not fire.
  - In ISSUE, the offered instruction is dropped and instr_valid goes low the next cycle.
  - In IDLE, redirect updates pc only.
- Simultaneous resume and redirect in HALTED: redirect wins; the result is IDLE then FETCH at redirect_pc.
- rst_n asserted mid-transaction returns all outputs to reset values immediately. Memory must tolerate the dropped mem_req.

Test Plan:
- Reset release, memory acks 2 cycles after req with 16'h1234 at 0x0000, instr_ready=1 -> mem_addr=0x0000; one ir_load pulse with ir_data=16'h1234; instr_valid for 1 cycle; pc=0x0001; next mem_req at 0x0001.
- instr_ready held low 5 cycles -> instr_valid stays 1 with ir_data stable; no mem_req until accept.
- Fetch 16'hF000 at pc=0x0010 -> after accept, halted=1 and mem_req=0 with pc=0x0011. Pulse resume -> fetch at 0x0011.
- redirect_pc=0x0100 asserted in the same cycle as mem_ack -> no ir_load; one IDLE cycle with mem_req=0; next fetch at 0x0100.
- pc=0xFFFF with ack -> pc wraps to 0x0000.
- No ack for TIMEOUT_CYCLES=64 cycles -> fetch_err=1 and mem_req=0; redirect ignored; rst_n low clears it.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction fetch sequencer for the 16-bit processor. Drives
//               the program counter and a single-outstanding req/ack read to
//               instruction memory. It strobes the fetched word into the
//               instruction register and offers it to decode with valid/ready.
//               It also handles redirects, HALT/resume and a fetch timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE    = 4'hF,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        ir_load,
  output logic [15:0] ir_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  // Last counter value of an unacknowledged fetch before giving up
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_data_q, ir_data_d;
  logic        ir_load_q, ir_load_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        mem_req_q, instr_valid_q, halted_q, fetch_err_q;

  // Next-state, PC, instruction word and timeout counter selection
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_data_d = ir_data_q;
    ir_load_d = 1'b0;
    tmo_cnt_d = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (redirect) pc_d = redirect_pc;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          // Dropping mem_req for one cycle cancels the read; any ack is discarded
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end else if (mem_ack) begin
          ir_data_d = mem_rdata;
          ir_load_d = 1'b1;
          pc_d      = pc_q + 16'd1;
          state_d   = S_ISSUE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_ERROR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end else if (instr_ready) begin
          state_d = (ir_data_q[15:12] == HALT_OPCODE) ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = S_IDLE;
        end else if (resume) begin
          state_d = S_FETCH;
        end
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_data_q     <= 16'h0000;
      ir_load_q     <= 1'b0;
      tmo_cnt_q     <= 8'd0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_data_q     <= ir_data_d;
      ir_load_q     <= ir_load_d;
      tmo_cnt_q     <= tmo_cnt_d;
      mem_req_q     <= (state_d == S_FETCH);
      instr_valid_q <= (state_d == S_ISSUE);
      halted_q      <= (state_d == S_HALTED);
      fetch_err_q   <= (state_d == S_ERROR);
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir_load     = ir_load_q;
  assign ir_data     = ir_data_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Randomized self-checking bench for fetch_sequencer, compared
//               cycle by cycle against a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        ir_load;
  logic [15:0] ir_data;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        resume = 1'b0;
  logic [15:0] pc;
  logic        halted;
  logic        fetch_err;

  fetch_sequencer #(
    .RESET_PC      (16'h0000),
    .HALT_OPCODE   (4'hF),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir_load    (ir_load),
    .ir_data    (ir_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .resume     (resume),
    .pc         (pc),
    .halted     (halted),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instruction memory contents, indexed by the low address byte
  logic [15:0] mem [0:255];

  // Behavioural model: what the sequencer is currently doing
  localparam int MD_IDLE = 0, MD_FETCH = 1, MD_ISSUE = 2, MD_HALT = 3, MD_ERR = 4;
  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic        m_load;
  int          m_waited;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = MD_IDLE;
    m_pc     = 16'h0000;
    m_ir     = 16'h0000;
    m_load   = 1'b0;
    m_waited = 0;
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic model_step();
    m_load = 1'b0;
    if (m_mode == MD_IDLE) begin
      if (redirect) m_pc = redirect_pc;
      m_mode   = MD_FETCH;
      m_waited = 0;
    end else if (m_mode == MD_FETCH) begin
      if (redirect) begin
        m_pc   = redirect_pc;
        m_mode = MD_IDLE;
      end else if (mem_ack) begin
        m_ir   = mem[m_pc[7:0]];
        m_load = 1'b1;
        m_pc   = m_pc + 16'd1;
        m_mode = MD_ISSUE;
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) m_mode = MD_ERR;
      end
    end else if (m_mode == MD_ISSUE) begin
      if (redirect) begin
        m_pc   = redirect_pc;
        m_mode = MD_IDLE;
      end else if (instr_ready) begin
        m_mode   = (m_ir[15:12] == 4'hF) ? MD_HALT : MD_FETCH;
        m_waited = 0;
      end
    end else if (m_mode == MD_HALT) begin
      if (redirect) begin
        m_pc   = redirect_pc;
        m_mode = MD_IDLE;
      end else if (resume) begin
        m_mode   = MD_FETCH;
        m_waited = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    check_eq("mem_req",     16'(mem_req),     16'(m_mode == MD_FETCH));
    check_eq("mem_addr",    mem_addr,         m_pc);
    check_eq("pc",          pc,               m_pc);
    check_eq("ir_load",     16'(ir_load),     16'(m_load));
    check_eq("ir_data",     ir_data,          m_ir);
    check_eq("instr_valid", 16'(instr_valid), 16'(m_mode == MD_ISSUE));
    check_eq("halted",      16'(halted),      16'(m_mode == MD_HALT));
    check_eq("fetch_err",   16'(fetch_err),   16'(m_mode == MD_ERR));
  endtask

  // One cycle: called at a negedge, checks, drives, clocks, leaves at next negedge
  task automatic drive_cycle(input int ack_pct, input int ready_pct, input int redir_pct,
                             input int resume_pct, input bit force_rpc,
                             input logic [15:0] rpc);
    compare_outputs();
    mem_ack     = mem_req && ($urandom_range(99) < ack_pct);
    mem_rdata   = mem[mem_addr[7:0]];
    instr_ready = ($urandom_range(99) < ready_pct);
    redirect    = ($urandom_range(99) < redir_pct);
    redirect_pc = force_rpc ? rpc : 16'($urandom);
    resume      = ($urandom_range(99) < resume_pct);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_ack     = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    resume      = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;

    // Mixed random traffic: latency, backpressure, redirects, halts, resumes
    for (int i = 0; i < 3000; i++) drive_cycle(40, 60, 5, 20, 1'b0, 16'h0000);

    // PC wrap: redirect to the top of memory, then fetch with immediate acks
    drive_cycle(40, 60, 100, 0, 1'b1, 16'hFFFF);
    for (int i = 0; i < 12; i++) drive_cycle(100, 100, 0, 100, 1'b0, 16'h0000);

    // Asynchronous reset mid-transaction
    rst_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    compare_outputs();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) drive_cycle(50, 50, 3, 30, 1'b0, 16'h0000);

    // Timeout: memory stops acknowledging
    for (int i = 0; i < TIMEOUT + 20; i++) drive_cycle(0, 100, 0, 100, 1'b0, 16'h0000);
    check_eq("timeout_err", 16'(fetch_err), 16'h0001);
    // Redirect and resume must not leave the error state
    for (int i = 0; i < 10; i++) drive_cycle(50, 50, 50, 50, 1'b0, 16'h0000);
    check_eq("err_sticky", 16'(fetch_err), 16'h0001);

    rst_n = 1'b0;
    clear_inputs();
    #1;
    model_reset();
    check_eq("err_cleared", 16'(fetch_err), 16'h0000);
    compare_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) drive_cycle(60, 70, 5, 30, 1'b0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
